// File: rtl/rf_wr_arbiter.sv
// Write-port arbiter for int_rf: fixed-priority WB pipe vs. buffered auxiliary
// results, with a starvation guard that stalls the pipe and a pending-rd busy mask.
module rf_wr_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pipe_we_i,
    input  logic [4:0]      pipe_rd_i,
    input  logic [XLEN-1:0] pipe_data_i,
    input  logic            aux_valid_i,
    input  logic [4:0]      aux_rd_i,
    input  logic [XLEN-1:0] aux_data_i,
    output logic            aux_ready_o,
    output logic            rf_we_o,
    output logic [4:0]      rf_dst_o,
    output logic [XLEN-1:0] rf_data_o,
    output logic            pipe_stall_o,
    output logic [31:0]     rd_busy_o
);

    localparam int unsigned RD_W  = 5;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_VALID = 1'b1
    } slot_state_t;

    slot_state_t      slot_q [DEPTH];
    slot_state_t      slot_d [DEPTH];
    logic [RD_W-1:0]  rd_q   [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] starve_q;
    logic [CNT_W-1:0] starve_d;
    logic [DEPTH-1:0] valid;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             pipe_go;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Occupancy decode from slot state registers only.
    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid[i] = (slot_q[i] == SLOT_VALID);
        end
    end

    assign full         = &valid;
    assign empty        = ~|valid;
    assign aux_ready_o  = ~full;
    assign pipe_go      = pipe_we_i && (pipe_rd_i != '0);
    assign push         = aux_valid_i && !full && (aux_rd_i != '0);
    assign pop          = !pipe_go && !empty;
    assign pipe_stall_o = (starve_q == CNT_W'(STARVE_MAX));

    // Per-slot next state: a push fills the tail slot, a pop frees the head slot.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_d[i] = slot_q[i];
            if (push && (wr_ptr_q == PTR_W'(i))) begin
                slot_d[i] = SLOT_VALID;
            end
            if (pop && (rd_ptr_q == PTR_W'(i))) begin
                slot_d[i] = SLOT_EMPTY;
            end
        end
    end

    // Starvation counter: counts cycles the head waits, saturating at the stall level.
    always_comb begin
        starve_d = starve_q;
        if (empty || pop) begin
            starve_d = '0;
        end else if (starve_q != CNT_W'(STARVE_MAX)) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    // Slot state, pointers and starvation counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= SLOT_EMPTY;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            starve_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
            if (push) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            starve_q <= starve_d;
        end
    end

    // Payload storage; contents are qualified by slot state, so no reset needed.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            rd_q[wr_ptr_q]   <= aux_rd_i;
            data_q[wr_ptr_q] <= aux_data_i;
        end
    end

    // Registered write port: pipe first, then FIFO head, else idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_o   <= 1'b0;
            rf_dst_o  <= '0;
            rf_data_o <= '0;
        end else if (pipe_go) begin
            rf_we_o   <= 1'b1;
            rf_dst_o  <= pipe_rd_i;
            rf_data_o <= pipe_data_i;
        end else if (pop) begin
            rf_we_o   <= 1'b1;
            rf_dst_o  <= rd_q[rd_ptr_q];
            rf_data_o <= data_q[rd_ptr_q];
        end else begin
            rf_we_o   <= 1'b0;
        end
    end

    // Busy mask: one bit per destination held by a valid FIFO entry.
    always_comb begin
        rd_busy_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) begin
                rd_busy_o[rd_q[i]] = 1'b1;
            end
        end
        rd_busy_o[0] = 1'b0;
    end

endmodule

// File: doc/rf_wr_arbiter.md
# rf_wr_arbiter

Arbiter and scheduler for the single write port of the integer register file (`int_rf`). It shares the port between the in-order WB stage, which has fixed priority and cannot be back-pressured, and an auxiliary long-latency result source such as a multi-cycle divider or late load return. The auxiliary source uses a valid/ready handshake into a small FIFO. A starvation guard stalls the pipe so the auxiliary source always makes progress, and a busy mask of pending destination registers is exported for hazard detection in ID.

## Interface
- `XLEN`, 32, data width of the register file.
- `DEPTH`, 2, number of auxiliary FIFO entries. Must be ≥1.
- `STARVE_MAX`, 4, number of cycles the FIFO head may be blocked before the pipe is stalled. Must be ≥1.

- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `pipe_we_i`  in  1  WB stage write request.
- `pipe_rd_i`  in  5  WB destination index.
- `pipe_data_i`  in  XLEN  WB write data.
- `aux_valid_i`  in  1  auxiliary result valid.
- `aux_rd_i`  in  5  auxiliary destination index.
- `aux_data_i`  in  XLEN  auxiliary result data.
- `aux_ready_o`  out  1  FIFO can accept an entry.
- `rf_we_o`  out  1  register-file write enable (registered).
- `rf_dst_o`  out  5  register-file write index (registered).
- `rf_data_o`  out  XLEN  register-file write data (registered).
- `pipe_stall_o`  out  1  pipe must issue no WB write this cycle.
- `rd_busy_o`  out  32  bit n set when a FIFO entry targets xn; bit 0 is always 0.

## Operation
**Handshake**
- `aux_ready_o` = !full. It is driven from registered occupancy only, with no combinational path from inputs.
- An entry is accepted when `aux_valid_i && aux_ready_o`.
- An accepted entry with `aux_rd_i`==0 completes the handshake and is discarded, not pushed.

**Grant, evaluated each cycle**
1. If `pipe_we_i && pipe_rd_i!=0`, the pipe write is registered to the port.
2. Otherwise, if the FIFO is non-empty, the head entry is registered to the port and popped.
3. Otherwise `rf_we_o` goes to 0 next cycle.

Additional grant rules:
- A pipe write to x0 never uses the port. The aux head may take the port in that cycle.
- Push and pop may occur in the same cycle. Occupancy is unchanged and the pushed entry goes to the tail.
- A newly pushed entry is never eligible in its own acceptance cycle.
- Entries drain strictly in FIFO order.
- Two entries with equal rd are both written, in order.

**Starvation guard**
- `starve_cnt` (0..STARVE_MAX):
  - cleared when the FIFO is empty or the head is popped;
  - otherwise incremented, saturating at STARVE_MAX.
- `pipe_stall_o` = (`starve_cnt`==STARVE_MAX), decoded from the register only.
- The environment guarantees `pipe_we_i`=0 while `pipe_stall_o`=1.
- If the pipe writes anyway, the pipe still wins and the counter holds at STARVE_MAX.

**Busy mask**
- `rd_busy_o` is the OR of one-hot(rd) over valid FIFO entries.
- It updates on the same edge as push and pop.

**State machine per FIFO slot**
- EMPTY → VALID on push.
- VALID → EMPTY on pop.
- Full = all slots VALID.
- Pointers wrap modulo DEPTH.

## Timing
**Reset** (synchronous, takes priority over all other updates):
- `rf_we_o`=0, `rf_dst_o`=0, `rf_data_o`=0.
- FIFO empty: `aux_ready_o`=1, `rd_busy_o`=0.
- `starve_cnt`=0, so `pipe_stall_o`=0.

**Reset mid-operation**
- Pending entries are dropped without being written.
- A handshake in the reset cycle is not accepted.

**Latency**
- Pipe write: request in cycle k appears on the `rf_*` outputs in cycle k+1.
- Aux write: accepted in cycle k, eligible from k+1, and on the outputs at k+2 at the earliest.

**Worst-case aux wait**
- With the head visible in cycle k and the pipe writing every cycle, `pipe_stall_o`=1 in cycle k+STARVE_MAX.
- The head is granted in that cycle and written at k+STARVE_MAX+1.
- `pipe_stall_o` deasserts in cycle k+STARVE_MAX+1.

**Full boundary**
- At full occupancy, `aux_ready_o`=0.
- After a pop in cycle k, `aux_ready_o`=1 in cycle k+1. There is no same-cycle refill while full.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `aux_valid_i`=1 → all outputs 0, `aux_ready_o`=1, no entry accepted.
- **Pipe only:** `pipe_we_i`=1, rd=5, data=0xDEADBEEF in cycle 3 → `rf_we_o`=1, `rf_dst_o`=5, `rf_data_o`=0xDEADBEEF in cycle 4; rd=0 request → `rf_we_o`=0.
- **Aux only:** accept rd=7, data=0x12 in cycle 2 → `rd_busy_o`[7]=1 in cycle 3; write visible in cycle 4; `rd_busy_o`=0 in cycle 4.
- **Full / back-pressure:**
  - Stimulus: pipe writes every cycle; push two aux entries (rd=1, rd=2).
  - Required: `aux_ready_o`=0 while full; `pipe_stall_o` rises 4 cycles after the first head is visible; rd=1 is written, then rd=2 after a further 5 cycles.
- **x0 discard:** aux push with rd=0 → handshake completes, occupancy unchanged, `rd_busy_o`=0, no write.
- **Simultaneous / mid-reset:**
  - Stimulus: pipe rd=3 and aux head rd=3 in the same cycle.
  - Required: pipe is written first, then aux next cycle.
  - Stimulus: assert `rst` with 2 entries pending.
  - Required: no writes are issued and `rd_busy_o`=0.
